// File: rtl/sram_ctrl.sv
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Asynchronous SRAM controller, single access in flight, split DQ.
//            Optional macro SRAM_CTRL_POWERDOWN_EN deasserts chip enables when idle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_ctrl #(
  parameter int RD_CYC   = 3,
  parameter int WR_CYC   = 3,
  parameter int TURN_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [16:0] addr,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic [16:0] sram_a,
  output logic        sram_ce_n,
  output logic        sram_ce2,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic [7:0]  sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [7:0]  sram_dq_i
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_TURN     = 3'd2;
  localparam logic [2:0] S_WR_SETUP = 3'd3;
  localparam logic [2:0] S_WR_PULSE = 3'd4;
  localparam logic [2:0] S_WR_HOLD  = 3'd5;

  localparam logic [3:0] RD_CNT   = 4'(RD_CYC);
  localparam logic [3:0] WR_CNT   = 4'(WR_CYC);
  localparam logic [3:0] TURN_CNT = 4'(TURN_CYC);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        active;

  // State register; async reset drops WE/OE/DQ_OE immediately via output decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 17'd0;
      wdata_q  <= 8'd0;
      wr_q     <= 1'b0;
      rdata_q  <= 8'd0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Next-state and datapath; wait counters count down to 1 then advance
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          wr_d    = wr;
          if (wr) begin
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_CNT;
          end
        end
      end
      S_RD: begin
        if (cnt_q == 4'd1) begin
          state_d  = S_TURN;
          cnt_d    = TURN_CNT;
          rdata_d  = sram_dq_i;
          rvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_TURN: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WR_CNT;
      end
      S_WR_PULSE: begin
        if (cnt_q == 4'd1) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    active     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
      end
      S_RD: begin
        sram_oe_n = 1'b0;
        active    = 1'b1;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        sram_dq_oe = 1'b1;
        active     = 1'b1;
      end
      S_WR_PULSE: begin
        sram_dq_oe = 1'b1;
        sram_we_n  = 1'b0;
        active     = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign sram_a    = addr_q;
  assign sram_dq_o = wdata_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;

`ifdef SRAM_CTRL_POWERDOWN_EN
  assign sram_ce_n = ~active;
  assign sram_ce2  = active;
`else
  logic unused_active;
  assign unused_active = active;
  assign sram_ce_n     = 1'b0;
  assign sram_ce2      = 1'b1;
`endif

endmodule

`default_nettype wire
